histogram_sched353: RTL and testbench
=====================================

# histogram_sched353

Sequencer sitting between the CPU register space and the histogram calculation block. It double-buffers the histogram window (left/top/width/height) and loads it into the histogram block at each frame start. On request, it reads out all 1024 bins of the completed bank through the histogram's address/rnext port into a valid/ready output stream, for example toward a DMA channel buffer. It is the only master of the histogram block's wen/wa/wd/rnext inputs.

## Interface
Parameters:
- HIST_WORDS, 1024, bins per readout (4 colors x 256).
- RD_LAT, 3, cycles from the start-address write to word 0 being stable on hist_do.

Ports:
- sclk  in  1  system clock; all registers update on negedge sclk, matching the histogram command side.
- rst  in  1  reset, synchronous, active-high.
- cpu_we  in  1  shadow register write strobe.
- cpu_wa  in  2  shadow register address: 0 left, 1 top, 2 width-1, 3 height-1.
- cpu_wd  in  16  shadow register data.
- frame_sync  in  1  one-cycle frame-start pulse, already in the sclk domain.
- rd_req  in  1  one-cycle request to read out the last completed bank.
- hist_wen  out  1  histogram register write strobe.
- hist_wa  out  3  histogram register address: 0..3 window, 4 readout start address.
- hist_wd  out  16  histogram register data, valid in the same cycle as hist_wen.
- hist_rnext  out  1  advance the histogram read pointer.
- hist_do  in  18  histogram bin value (low 18 bits of the histogram output word).
- out_data  out  18  bin value.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accept.
- out_last  out  1  asserted with bin 1023.
- busy  out  1  state is not IDLE.
- ovr  out  1  sticky flag: frame_sync arrived during a readout. Cleared by rst or by rd_req.

## Operation
- Shadow registers (4 x 16) and a dirty flag.
  - Any cpu_we sets dirty.
  - Reset clears the shadows to 0 and sets dirty=1.
- State machine states: IDLE, CFG, ADDR, WAIT, SEND, NEXT.
- IDLE:
  - Pending config has priority over pending read.
  - pend_cfg && dirty -> CFG. Snapshot the 4 shadows, clear dirty and pend_cfg. A cpu_we in the same cycle re-sets dirty.
  - pend_cfg && !dirty: clear pend_cfg and stay in IDLE.
  - Otherwise pend_rd -> ADDR, clear pend_rd.
- pend_cfg is set by frame_sync in any state. pend_rd is set by rd_req in any state.
- CFG: 4 consecutive cycles with hist_wen=1, hist_wa=0,1,2,3, hist_wd = snapshot word. Then -> IDLE.
- ADDR: 1 cycle with hist_wen=1, hist_wa=4, hist_wd=0; clear bin counter. Then -> WAIT.
- WAIT: RD_LAT cycles, then capture hist_do into out_data, set out_valid, go to SEND.
- SEND: hold out_data/out_valid until out_ready.
  - On accept with bin counter = HIST_WORDS-1: drop out_valid -> IDLE.
  - Otherwise: drop out_valid, pulse hist_rnext, increment counter -> NEXT.
- NEXT: 1 cycle; capture hist_do into out_data, set out_valid -> SEND.
- out_last = out_valid && counter == HIST_WORDS-1.
- A frame_sync during ADDR/WAIT/SEND/NEXT sets ovr. The readout continues to completion and pend_cfg is serviced afterwards. Data after the bank swap is not guaranteed.
- rd_req while busy in readout: pend_rd is set, giving exactly one more full readout afterwards.
- Bin counter is 10 bits and never wraps within a readout.

## Timing
- Reset values: hist_wen=0, hist_wa=0, hist_wd=0, hist_rnext=0, out_valid=0, out_last=0, out_data=0, busy=0, ovr=0; state IDLE, pend_cfg=0, pend_rd=0.
- frame_sync in cycle t, state IDLE: snapshot at edge t+1, hist_wen in cycles t+1..t+4.
- rd_req in cycle t, state IDLE: ADDR at t+1, word 0 valid at t+2+RD_LAT.
- Per-word throughput: 2 cycles with out_ready held high, so 2048+RD_LAT+2 cycles per readout.
- hist_rnext in cycle j: the new word is sampled at the end of cycle j+1, never earlier.
- hist_wen and hist_rnext are never asserted in the same cycle.
- rst mid-operation: return to IDLE next edge, all outputs to reset values, pending flags and ovr cleared; a partial stream is abandoned with no out_last.

## Test plan
- Reset, frame_sync -> 4 writes of 0 to wa 0..3 in consecutive cycles. A second frame_sync with no cpu_we -> no writes.
- cpu writes left=0x40, top=0x20, width-1=0x13F, height-1=0xEF, then frame_sync -> hist_wd sequence 0x40, 0x20, 0x13F, 0xEF.
- Histogram model returning bin index+5, rd_req with out_ready=1 -> 1024 words 5..1028, out_last only on 1028, exactly 1023 hist_rnext pulses.
- out_ready random 30% duty -> identical data sequence, out_data stable while stalled.
- frame_sync at word 500 -> ovr=1, stream completes, then 4 config writes follow; next rd_req clears ovr.
- rst asserted at word 10 -> out_valid=0 next cycle, busy=0, no further hist_rnext.

Source files
------------

// File: rtl/histogram_sched353.sv
// rtl/histogram_sched353.sv - histogram window double-buffer and bin readout sequencer
module histogram_sched353 #(
  parameter int HIST_WORDS = 1024,
  parameter int RD_LAT     = 3
) (
  input  logic        sclk,
  input  logic        rst,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_wa,
  input  logic [15:0] cpu_wd,
  input  logic        frame_sync,
  input  logic        rd_req,
  output logic        hist_wen,
  output logic [2:0]  hist_wa,
  output logic [15:0] hist_wd,
  output logic        hist_rnext,
  input  logic [17:0] hist_do,
  output logic [17:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        ovr
);

  localparam int         WW       = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [9:0] LAST_BIN = 10'(HIST_WORDS - 1);
  localparam logic [WW-1:0] WAIT_INIT = WW'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CFG  = 3'd1,
    S_ADDR = 3'd2,
    S_WAIT = 3'd3,
    S_SEND = 3'd4,
    S_NEXT = 3'd5
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [15:0]   shadow [4];
  logic [15:0]   snap   [4];
  logic          dirty;
  logic          pend_cfg;
  logic          pend_rd;
  logic [1:0]    cfg_idx;
  logic [9:0]    bin_cnt;
  logic [WW-1:0] wait_cnt;

  // A pulse arriving in the same cycle counts as already pending, so IDLE
  // reacts without an extra cycle of latency.
  logic eff_cfg;
  logic eff_rd;
  logic take_cfg;
  logic load_cfg;
  logic take_rd;
  logic accept;
  logic last_bin;
  logic readout;
  logic capture;

  assign eff_cfg  = pend_cfg | frame_sync;
  assign eff_rd   = pend_rd | rd_req;
  assign take_cfg = (state == S_IDLE) && eff_cfg;
  assign load_cfg = take_cfg && dirty;
  assign take_rd  = (state == S_IDLE) && !eff_cfg && eff_rd;
  assign accept   = (state == S_SEND) && out_ready;
  assign last_bin = (bin_cnt == LAST_BIN);
  assign readout  = (state == S_ADDR) || (state == S_WAIT) ||
                    (state == S_SEND) || (state == S_NEXT);
  assign capture  = ((state == S_WAIT) && (wait_cnt == '0)) || (state == S_NEXT);

  // State register, updated on the falling edge like the histogram command side
  always_ff @(negedge sclk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state selection; config beats readout when both are pending in IDLE
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (eff_cfg) begin
          if (dirty) state_nx = S_CFG;
        end else if (eff_rd) begin
          state_nx = S_ADDR;
        end
      end
      S_CFG:   if (cfg_idx == 2'd3) state_nx = S_IDLE;
      S_ADDR:  state_nx = S_WAIT;
      S_WAIT:  if (wait_cnt == '0) state_nx = S_SEND;
      S_SEND:  if (out_ready) state_nx = last_bin ? S_IDLE : S_NEXT;
      S_NEXT:  state_nx = S_SEND;
      default: state_nx = S_IDLE;
    endcase
  end

  // Histogram command port and status outputs decoded from the current state
  always_comb begin
    hist_wen   = 1'b0;
    hist_wa    = 3'd0;
    hist_wd    = 16'd0;
    hist_rnext = 1'b0;
    busy       = (state != S_IDLE);
    out_last   = out_valid && last_bin;
    case (state)
      S_CFG: begin
        hist_wen = 1'b1;
        hist_wa  = {1'b0, cfg_idx};
        hist_wd  = snap[cfg_idx];
      end
      S_ADDR: begin
        hist_wen = 1'b1;
        hist_wa  = 3'd4;
      end
      S_SEND: hist_rnext = out_ready && !last_bin;
      default: ;
    endcase
  end

  // CPU-side shadow window registers; any write marks the window dirty
  always_ff @(negedge sclk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) shadow[i] <= 16'd0;
      dirty <= 1'b1;
    end else begin
      if (cpu_we) shadow[cpu_wa] <= cpu_wd;
      if (cpu_we)        dirty <= 1'b1;
      else if (load_cfg) dirty <= 1'b0;
    end
  end

  // Snapshot of the window taken when a config load starts, and the write index
  always_ff @(negedge sclk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) snap[i] <= 16'd0;
      cfg_idx <= 2'd0;
    end else begin
      if (load_cfg) for (int i = 0; i < 4; i++) snap[i] <= shadow[i];
      cfg_idx <= (state == S_CFG) ? cfg_idx + 2'd1 : 2'd0;
    end
  end

  // Pending frame-start and read requests, consumed only from IDLE
  always_ff @(negedge sclk) begin
    if (rst) begin
      pend_cfg <= 1'b0;
      pend_rd  <= 1'b0;
    end else begin
      if (take_cfg)        pend_cfg <= 1'b0;
      else if (frame_sync) pend_cfg <= 1'b1;
      if (take_rd)         pend_rd  <= 1'b0;
      else if (rd_req)     pend_rd  <= 1'b1;
    end
  end

  // Bin counter and the start-address latency counter
  always_ff @(negedge sclk) begin
    if (rst) begin
      bin_cnt  <= 10'd0;
      wait_cnt <= '0;
    end else begin
      if (state == S_ADDR)         bin_cnt <= 10'd0;
      else if (accept && !last_bin) bin_cnt <= bin_cnt + 10'd1;
      if (state == S_ADDR)                         wait_cnt <= WAIT_INIT;
      else if ((state == S_WAIT) && (wait_cnt != '0)) wait_cnt <= wait_cnt - 1'b1;
    end
  end

  // Output word register: load from the histogram, hold until accepted
  always_ff @(negedge sclk) begin
    if (rst) begin
      out_data  <= 18'd0;
      out_valid <= 1'b0;
    end else if (capture) begin
      out_data  <= hist_do;
      out_valid <= 1'b1;
    end else if (accept) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky overrun: a frame started while a bank was being read out
  always_ff @(negedge sclk) begin
    if (rst)                      ovr <= 1'b0;
    else if (readout && frame_sync) ovr <= 1'b1;
    else if (rd_req)              ovr <= 1'b0;
  end

endmodule

// File: tb/tb_histogram_sched353.sv
// tb/tb_histogram_sched353.sv - randomized self-checking bench for histogram_sched353
module tb_histogram_sched353;
  localparam int RD_LAT = 3;
  localparam int HW     = 1024;

  logic        sclk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_we = 1'b0;
  logic [1:0]  cpu_wa = 2'd0;
  logic [15:0] cpu_wd = 16'd0;
  logic        frame_sync = 1'b0;
  logic        rd_req = 1'b0;
  logic        out_ready = 1'b0;
  logic        hist_wen, hist_rnext, out_valid, out_last, busy, ovr;
  logic [2:0]  hist_wa;
  logic [15:0] hist_wd;
  logic [17:0] hist_do, out_data;

  histogram_sched353 #(.HIST_WORDS(HW), .RD_LAT(RD_LAT)) dut (
    .sclk(sclk), .rst(rst), .cpu_we(cpu_we), .cpu_wa(cpu_wa), .cpu_wd(cpu_wd),
    .frame_sync(frame_sync), .rd_req(rd_req), .hist_wen(hist_wen), .hist_wa(hist_wa),
    .hist_wd(hist_wd), .hist_rnext(hist_rnext), .hist_do(hist_do), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .busy(busy), .ovr(ovr)
  );

  always #5 sclk = ~sclk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  always @(posedge sclk) cyc <= cyc + 1;

  // Histogram block model: bin i reads as i+5, garbage until the start address settles
  logic [9:0] hptr = 10'd0;
  int hramp = 0;
  always @(negedge sclk) begin
    if (rst) begin
      hptr <= 10'd0;
      hramp <= 0;
    end else if (hist_wen && hist_wa == 3'd4) begin
      hptr <= hist_wd[9:0];
      hramp <= RD_LAT - 1;
    end else begin
      if (hist_rnext) hptr <= hptr + 10'd1;
      if (hramp > 0) hramp <= hramp - 1;
    end
  end
  assign hist_do = (hramp != 0) ? 18'h2beef : ({8'd0, hptr} + 18'd5);

  // Observation of the DUT in mid-cycle, well away from the falling edge
  logic [2:0]  wr_wa_q[$];
  logic [15:0] wr_wd_q[$];
  int          wr_cyc_q[$];
  logic [17:0] st_data_q[$];
  bit          st_last_q[$];
  int          st_cyc_q[$];
  int rnext_cnt = 0, clash_cnt = 0, stall_err = 0, first_valid_cyc = -1;
  bit prev_stall = 0;
  logic [17:0] prev_data = '0;

  always begin
    @(posedge sclk);
    #3;
    if (hist_wen) begin
      wr_wa_q.push_back(hist_wa); wr_wd_q.push_back(hist_wd); wr_cyc_q.push_back(cyc);
    end
    if (hist_rnext) rnext_cnt++;
    if (hist_wen && hist_rnext) clash_cnt++;
    if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (out_valid && out_ready) begin
      st_data_q.push_back(out_data); st_last_q.push_back(out_last); st_cyc_q.push_back(cyc);
    end
    if (prev_stall && (!out_valid || out_data !== prev_data)) stall_err++;
    prev_stall = out_valid && !out_ready && !rst;
    prev_data = out_data;
  end

  task automatic clear_mon();
    wr_wa_q.delete(); wr_wd_q.delete(); wr_cyc_q.delete();
    st_data_q.delete(); st_last_q.delete(); st_cyc_q.delete();
    rnext_cnt = 0; clash_cnt = 0; stall_err = 0; first_valid_cyc = -1;
  endtask

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  logic [15:0] sh [4];

  task automatic cpu_write(input logic [1:0] a, input logic [15:0] d);
    step();
    cpu_we = 1'b1; cpu_wa = a; cpu_wd = d;
    sh[a] = d;
  endtask

  task automatic pulse_fs(output int c);
    step();
    cpu_we = 1'b0; frame_sync = 1'b1; c = cyc;
    step();
    frame_sync = 1'b0;
  endtask

  task automatic pulse_rd(output int c);
    step();
    cpu_we = 1'b0; rd_req = 1'b1; c = cyc;
    step();
    rd_req = 1'b0;
  endtask

  task automatic run_readout(input int pct, input int fs_at, input int rst_at, output bit timed_out);
    int budget = 20000;
    bit done = 0, fs_done = 0;
    while (!done && budget > 0) begin
      step();
      out_ready = ($urandom_range(99) < pct);
      frame_sync = 1'b0;
      if (fs_at >= 0 && !fs_done && st_data_q.size() >= fs_at) begin
        frame_sync = 1'b1; fs_done = 1;
      end
      if (rst_at >= 0 && st_data_q.size() >= rst_at) begin
        rst = 1'b1; done = 1;
      end
      if (st_data_q.size() >= HW && !busy) done = 1;
      budget--;
    end
    frame_sync = 1'b0;
    out_ready = 1'b1;
    timed_out = !done;
  endtask

  task automatic check_stream(input string tag);
    int errs = 0, lasts = 0;
    n_total++;
    if (st_data_q.size() !== HW) $display("FAIL %s_count: got %0d want %0d", tag, st_data_q.size(), HW);
    else n_pass++;
    for (int i = 0; i < st_data_q.size(); i++) begin
      if (st_data_q[i] !== 18'(i + 5)) errs++;
      if (st_last_q[i]) lasts++;
    end
    n_total++;
    if (errs !== 0) $display("FAIL %s_data: got %0d bad words want 0", tag, errs);
    else n_pass++;
    n_total++;
    if (lasts !== 1 || st_last_q.size() != HW || st_last_q[HW-1] !== 1'b1)
      $display("FAIL %s_last: got %0d last flags want exactly 1 on word %0d", tag, lasts, HW - 1);
    else n_pass++;
    n_total++;
    if (rnext_cnt !== HW - 1) $display("FAIL %s_rnext: got %0d want %0d", tag, rnext_cnt, HW - 1);
    else n_pass++;
    n_total++;
    if (clash_cnt !== 0) $display("FAIL %s_wen_rnext_clash: got %0d want 0", tag, clash_cnt);
    else n_pass++;
  endtask

  task automatic check_cfg_writes(input string tag, input int base, input int start_cyc);
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (wr_wa_q.size() <= base + i) $display("FAIL %s_w%0d: got no write want wa=%0d wd=%h", tag, i, i, sh[i]);
      else if (wr_wa_q[base+i] !== 3'(i) || wr_wd_q[base+i] !== sh[i] || wr_cyc_q[base+i] !== start_cyc + i)
        $display("FAIL %s_w%0d: got wa=%0d wd=%h cyc=%0d want wa=%0d wd=%h cyc=%0d", tag, i,
                 wr_wa_q[base+i], wr_wd_q[base+i], wr_cyc_q[base+i], i, sh[i], start_cyc + i);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    n_total++;
    if ({hist_wen, hist_rnext, out_valid, out_last, busy, ovr} !== 6'b0)
      $display("FAIL reset_flags: got wen=%b rnext=%b valid=%b last=%b busy=%b ovr=%b want all 0",
               hist_wen, hist_rnext, out_valid, out_last, busy, ovr);
    else n_pass++;
    n_total++;
    if ({hist_wa, hist_wd, out_data} !== 37'd0)
      $display("FAIL reset_buses: got wa=%0d wd=%h data=%h want 0", hist_wa, hist_wd, out_data);
    else n_pass++;
    for (int i = 0; i < 4; i++) sh[i] = 16'd0;
    rst = 1'b0;
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_cfg_default();
    int c;
    clear_mon();
    pulse_fs(c);
    repeat (8) step();
    n_total++;
    if (wr_wa_q.size() !== 4) $display("FAIL cfg0_count: got %0d want 4", wr_wa_q.size());
    else n_pass++;
    check_cfg_writes("cfg0", 0, c + 1);
    clear_mon();
    pulse_fs(c);
    repeat (8) step();
    n_total++;
    if (wr_wa_q.size() !== 0) $display("FAIL cfg_clean_count: got %0d want 0", wr_wa_q.size());
    else n_pass++;
  endtask

  task automatic test_cfg_values();
    int c;
    cpu_write(2'd0, 16'h0040);
    cpu_write(2'd1, 16'h0020);
    cpu_write(2'd2, 16'h013f);
    cpu_write(2'd3, 16'h00ef);
    clear_mon();
    pulse_fs(c);
    repeat (8) step();
    check_cfg_writes("cfg_fixed", 0, c + 1);
    for (int r = 0; r < 2; r++) begin
      int n = $urandom_range(6, 2);
      for (int k = 0; k < n; k++) cpu_write(2'($urandom_range(3)), 16'($urandom));
      clear_mon();
      pulse_fs(c);
      repeat (8) step();
      n_total++;
      if (wr_wa_q.size() !== 4) $display("FAIL cfg_rand%0d_count: got %0d want 4", r, wr_wa_q.size());
      else n_pass++;
      check_cfg_writes("cfg_rand", 0, c + 1);
    end
  endtask

  task automatic test_readout();
    int c;
    bit to;
    clear_mon();
    out_ready = 1'b1;
    pulse_rd(c);
    run_readout(100, -1, -1, to);
    n_total++;
    if (to) $display("FAIL rd_timeout: got timeout want completion");
    else n_pass++;
    check_stream("rd");
    n_total++;
    if (first_valid_cyc !== c + 2 + RD_LAT)
      $display("FAIL rd_first_latency: got cycle %0d want %0d", first_valid_cyc, c + 2 + RD_LAT);
    else n_pass++;
    n_total++;
    if (st_cyc_q.size() != HW || st_cyc_q[HW-1] - st_cyc_q[0] !== 2 * (HW - 1))
      $display("FAIL rd_throughput: got span %0d want %0d", (st_cyc_q.size() == HW) ? st_cyc_q[HW-1] - st_cyc_q[0] : -1, 2 * (HW - 1));
    else n_pass++;
    n_total++;
    if (wr_wa_q.size() !== 1 || wr_wa_q[0] !== 3'd4 || wr_wd_q[0] !== 16'd0 || wr_cyc_q[0] !== c + 1)
      $display("FAIL rd_addr_write: got %0d writes want one wa=4 wd=0 at cycle %0d", wr_wa_q.size(), c + 1);
    else n_pass++;
  endtask

  task automatic test_stall();
    int c;
    bit to;
    clear_mon();
    pulse_rd(c);
    run_readout(30, -1, -1, to);
    n_total++;
    if (to) $display("FAIL stall_timeout: got timeout want completion");
    else n_pass++;
    check_stream("stall");
    n_total++;
    if (stall_err !== 0) $display("FAIL stall_hold: got %0d unstable stalled cycles want 0", stall_err);
    else n_pass++;
  endtask

  task automatic test_ovr();
    int c;
    bit to;
    for (int k = 0; k < 4; k++) cpu_write(2'(k), 16'($urandom));
    clear_mon();
    out_ready = 1'b1;
    pulse_rd(c);
    run_readout(100, 500, -1, to);
    repeat (8) step();
    n_total++;
    if (to) $display("FAIL ovr_timeout: got timeout want completion");
    else n_pass++;
    n_total++;
    if (ovr !== 1'b1) $display("FAIL ovr_set: got %b want 1", ovr);
    else n_pass++;
    check_stream("ovr");
    n_total++;
    if (wr_wa_q.size() !== 5) $display("FAIL ovr_cfg_count: got %0d want 5", wr_wa_q.size());
    else n_pass++;
    n_total++;
    if (wr_cyc_q.size() < 2 || st_cyc_q.size() < HW || wr_cyc_q[1] <= st_cyc_q[HW-1])
      $display("FAIL ovr_cfg_after_stream: got cfg before stream end want after");
    else n_pass++;
    if (wr_cyc_q.size() >= 2) check_cfg_writes("ovr_cfg", 1, wr_cyc_q[1]);
    clear_mon();
    pulse_rd(c);
    step();
    n_total++;
    if (ovr !== 1'b0) $display("FAIL ovr_clear: got %b want 0", ovr);
    else n_pass++;
    run_readout(100, -1, -1, to);
    n_total++;
    if (to || st_data_q.size() !== HW) $display("FAIL ovr_rd2: got %0d words want %0d", st_data_q.size(), HW);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int c, rn, nw;
    bit to;
    clear_mon();
    pulse_rd(c);
    run_readout(100, -1, 10, to);
    step();
    rst = 1'b0;
    n_total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || ovr !== 1'b0)
      $display("FAIL rstmid_outputs: got valid=%b busy=%b ovr=%b want 0 0 0", out_valid, busy, ovr);
    else n_pass++;
    rn = rnext_cnt;
    nw = wr_wa_q.size();
    repeat (20) step();
    n_total++;
    if (rnext_cnt !== rn) $display("FAIL rstmid_rnext: got %0d pulses want %0d", rnext_cnt, rn);
    else n_pass++;
    n_total++;
    if (wr_wa_q.size() !== nw || busy !== 1'b0)
      $display("FAIL rstmid_idle: got %0d writes busy=%b want %0d writes busy=0", wr_wa_q.size(), busy, nw);
    else n_pass++;
    n_total++;
    if (st_last_q.size() < 10 || st_last_q.size() > 12 || st_last_q[st_last_q.size()-1] !== 1'b0)
      $display("FAIL rstmid_partial: got %0d words want about 10 with no last", st_last_q.size());
    else n_pass++;
    for (int i = 0; i < 4; i++) sh[i] = 16'd0;
    clear_mon();
    pulse_fs(c);
    repeat (8) step();
    check_cfg_writes("rstmid_cfg", 0, c + 1);
  endtask

  initial begin
    test_reset();
    test_cfg_default();
    test_cfg_values();
    test_readout();
    test_stall();
    test_ovr();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
